// File: rtl/gelato_wb_arbiter_pkg.sv
// Shared types for the writeback arbiter: register/warp widths and the buffered writeback entry.
package gelato_wb_arbiter_pkg;

    localparam int unsigned WARP_NUM   = 8;
    localparam int unsigned WARP_W     = $clog2(WARP_NUM);
    localparam int unsigned REG_W      = 6;
    localparam int unsigned WB_DATA_W  = 32;
    localparam int unsigned WB_SRC_NUM = 4;

    typedef logic [REG_W-1:0] reg_num_t;

    typedef struct packed {
        logic [WARP_W-1:0]    warp;
        reg_num_t             reg_num;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/gelato_wb_fifo.sv
// Per-source writeback FIFO; full/empty come from the occupancy count, so pointers simply wrap.
module gelato_wb_fifo
    import gelato_wb_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enq,
    input  logic             deq,
    input  wb_entry_t        din,
    output wb_entry_t        head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    wb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
            if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(enq) - CNT_W'(deq);
        end
    end

    // Storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (enq) mem[wr_ptr] <= din;
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/gelato_wb_arbiter.sv
// Round-robin writeback arbiter: per-source FIFOs serialised onto one valid/ack channel.
// Optional stall counters are enabled with `define GELATO_WB_PERF_EN.
module gelato_wb_arbiter
    import gelato_wb_arbiter_pkg::*;
#(
    parameter int unsigned NUM_SRC    = WB_SRC_NUM,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned DATA_W     = 32,
    localparam int unsigned IDX_W     = $clog2(NUM_SRC)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             rdy,
    input  logic [NUM_SRC-1:0]               src_valid,
    output logic [NUM_SRC-1:0]               src_ready,
    input  logic [NUM_SRC-1:0][WARP_W-1:0]   src_warp,
    input  reg_num_t [NUM_SRC-1:0]           src_reg,
    input  logic [NUM_SRC-1:0][DATA_W-1:0]   src_data,
    output logic                             wb_valid,
    input  logic                             wb_ack,
    output logic [WARP_W-1:0]                wb_warp,
    output reg_num_t                         wb_reg,
    output logic [DATA_W-1:0]                wb_data,
    output logic [IDX_W-1:0]                 wb_src
`ifdef GELATO_WB_PERF_EN
    ,
    output logic [NUM_SRC-1:0][15:0]         perf_stall_cnt
`endif
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    wb_entry_t          din       [NUM_SRC];
    wb_entry_t          head      [NUM_SRC];
    logic [CNT_W-1:0]   fifo_cnt  [NUM_SRC];
    logic [NUM_SRC-1:0] enq;
    logic [NUM_SRC-1:0] deq;
    logic [NUM_SRC-1:0] full;
    logic [NUM_SRC-1:0] empty;
    logic [IDX_W-1:0]   last_grant;
    logic [IDX_W-1:0]   start_idx;
    logic [IDX_W-1:0]   grant;
    logic               out_free;
    logic               fire;

    // Rotate requests so start is bit 0, take the lowest set bit, rotate back.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_SRC-1:0] req,
                                                 input logic [IDX_W-1:0]   start);
        logic [NUM_SRC-1:0] rot;
        int                 pick;
        for (int k = 0; k < int'(NUM_SRC); k++)
            rot[k] = req[IDX_W'((int'(start) + k) % int'(NUM_SRC))];
        pick = 0;
        for (int k = int'(NUM_SRC) - 1; k >= 0; k--)
            if (rot[k]) pick = k;
        return IDX_W'((int'(start) + pick) % int'(NUM_SRC));
    endfunction

    always_comb begin
        start_idx = (last_grant == IDX_W'(NUM_SRC - 1)) ? '0 : last_grant + IDX_W'(1);
        grant     = rr_pick(~empty, start_idx);
        out_free  = !wb_valid || wb_ack;
        fire      = rdy && out_free && (|(~empty));
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            src_ready[i]   = rdy && !rst && (fifo_cnt[i] < CNT_W'(FIFO_DEPTH));
            enq[i]         = src_valid[i] && src_ready[i] && (src_reg[i] != '0);
            deq[i]         = fire && (grant == IDX_W'(i));
            din[i].warp    = src_warp[i];
            din[i].reg_num = src_reg[i];
            din[i].data    = WB_DATA_W'(src_data[i]);
        end
    end

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_fifo
        gelato_wb_fifo #(
            .DEPTH (FIFO_DEPTH),
            .CNT_W (CNT_W)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .enq   (enq[g]),
            .deq   (deq[g]),
            .din   (din[g]),
            .head  (head[g]),
            .full  (full[g]),
            .empty (empty[g]),
            .count (fifo_cnt[g])
        );

        always_ff @(posedge clk) begin
            if (!rst && enq[g]) assert (!full[g]);
        end
    end

    // Output register: reload on ack or when empty; hold while presented and not taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid   <= 1'b0;
            wb_warp    <= '0;
            wb_reg     <= '0;
            wb_data    <= '0;
            wb_src     <= '0;
            last_grant <= IDX_W'(NUM_SRC - 1);
        end else if (rdy && out_free) begin
            if (fire) begin
                wb_valid   <= 1'b1;
                wb_warp    <= head[grant].warp;
                wb_reg     <= head[grant].reg_num;
                wb_data    <= DATA_W'(head[grant].data);
                wb_src     <= grant;
                last_grant <= grant;
            end else begin
                wb_valid   <= 1'b0;
            end
        end
    end

`ifdef GELATO_WB_PERF_EN
    // A source stalls when it is refused, or it has a head waiting that was not granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cnt <= '0;
        end else if (rdy) begin
            for (int i = 0; i < int'(NUM_SRC); i++) begin
                if (((src_valid[i] && !src_ready[i]) || (!empty[i] && !deq[i]))
                    && (perf_stall_cnt[i] != 16'hFFFF))
                    perf_stall_cnt[i] <= perf_stall_cnt[i] + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_gelato_wb_arbiter.sv
// Self-checking bench for gelato_wb_arbiter against a queue-based transaction model.
module tb_gelato_wb_arbiter;
    import gelato_wb_arbiter_pkg::*;

    localparam int N = 4;
    localparam int D = 4;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      rdy;
    logic [N-1:0]              src_valid;
    logic [N-1:0]              src_ready;
    logic [N-1:0][WARP_W-1:0]  src_warp;
    reg_num_t [N-1:0]          src_reg;
    logic [N-1:0][31:0]        src_data;
    logic                      wb_valid;
    logic                      wb_ack;
    logic [WARP_W-1:0]         wb_warp;
    reg_num_t                  wb_reg;
    logic [31:0]               wb_data;
    logic [1:0]                wb_src;
`ifdef GELATO_WB_PERF_EN
    logic [N-1:0][15:0]        perf_stall_cnt;
`endif

    gelato_wb_arbiter #(.NUM_SRC(N), .FIFO_DEPTH(D), .DATA_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .rdy       (rdy),
        .src_valid (src_valid),
        .src_ready (src_ready),
        .src_warp  (src_warp),
        .src_reg   (src_reg),
        .src_data  (src_data),
        .wb_valid  (wb_valid),
        .wb_ack    (wb_ack),
        .wb_warp   (wb_warp),
        .wb_reg    (wb_reg),
        .wb_data   (wb_data),
        .wb_src    (wb_src)
`ifdef GELATO_WB_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: one queue per source plus the presented entry.
    wb_entry_t         mq [N][$];
    logic              m_valid;
    logic [WARP_W-1:0] m_warp;
    reg_num_t          m_reg;
    logic [31:0]       m_data;
    int                m_src;
    int                m_last;

    task automatic idle();
        src_valid = '0;
        src_warp  = '0;
        src_reg   = '0;
        src_data  = '0;
    endtask

    task automatic drive_random(input int valid_pct);
        for (int i = 0; i < N; i++) begin
            src_valid[i] = ($urandom_range(99) < valid_pct);
            src_warp[i]  = WARP_W'($urandom);
            src_reg[i]   = ($urandom_range(7) == 0) ? reg_num_t'(0) : reg_num_t'($urandom_range(63, 1));
            src_data[i]  = $urandom;
        end
    endtask

    // Called at a negedge with inputs set: checks ready, advances the model, checks outputs after the edge.
    task automatic step();
        logic [N-1:0] exp_rdy;
        logic         found;
        int           s;
        wb_entry_t    e;
        #1;
        for (int i = 0; i < N; i++)
            exp_rdy[i] = rdy && !rst && (mq[i].size() < D);
        n_checks++;
        if (src_ready !== exp_rdy)
            $display("FAIL src_ready: got %b expected %b at %0t", src_ready, exp_rdy, $time);
        else n_pass++;

        if (rst) begin
            for (int i = 0; i < N; i++) mq[i].delete();
            m_valid = 1'b0; m_warp = '0; m_reg = '0; m_data = '0; m_src = 0; m_last = N - 1;
        end else if (rdy) begin
            if (!m_valid || wb_ack) begin
                found = 1'b0;
                for (int k = 1; k <= N; k++) begin
                    s = (m_last + k) % N;
                    if (!found && mq[s].size() > 0) begin
                        e       = mq[s].pop_front();
                        found   = 1'b1;
                        m_warp  = e.warp;
                        m_reg   = e.reg_num;
                        m_data  = e.data;
                        m_src   = s;
                        m_last  = s;
                    end
                end
                m_valid = found;
            end
            for (int i = 0; i < N; i++) begin
                if (src_valid[i] && exp_rdy[i] && src_reg[i] != '0) begin
                    e.warp = src_warp[i]; e.reg_num = src_reg[i]; e.data = src_data[i];
                    mq[i].push_back(e);
                end
            end
        end

        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (wb_valid !== m_valid)
            $display("FAIL wb_valid: got %b expected %b at %0t", wb_valid, m_valid, $time);
        else n_pass++;
        if (m_valid) begin
            n_checks++;
            if ({wb_src, wb_warp, wb_reg, wb_data} !== {2'(m_src), m_warp, m_reg, m_data})
                $display("FAIL wb_entry: got src=%0d warp=%0d reg=%0d data=%h expected src=%0d warp=%0d reg=%0d data=%h at %0t",
                         wb_src, wb_warp, wb_reg, wb_data, m_src, m_warp, m_reg, m_data, $time);
            else n_pass++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; rdy = 1'b1; wb_ack = 1'b0; idle();
        step(); step();
        n_checks++;
        if ({wb_valid, wb_warp, wb_reg, wb_data, wb_src} !== '0)
            $display("FAIL reset_outputs: got valid=%b warp=%0d reg=%0d data=%h src=%0d expected all zero",
                     wb_valid, wb_warp, wb_reg, wb_data, wb_src);
        else n_pass++;
        rst = 1'b0;
        step();
        n_checks++;
        if (src_ready !== 4'hF) $display("FAIL ready_after_reset: got %b expected 1111", src_ready);
        else n_pass++;
    endtask

    task automatic test_single();
        idle(); wb_ack = 1'b1;
        src_valid[0] = 1'b1; src_warp[0] = 3'd2; src_reg[0] = 6'd5; src_data[0] = 32'hA5;
        step();
        idle();
        n_checks++;
        if (wb_valid !== 1'b0) $display("FAIL single_early: got valid %b expected 0", wb_valid);
        else n_pass++;
        step();
        n_checks++;
        if ({wb_valid, wb_warp, wb_reg, wb_data, wb_src} !== {1'b1, 3'd2, 6'd5, 32'hA5, 2'd0})
            $display("FAIL single_entry: got valid=%b warp=%0d reg=%0d data=%h src=%0d expected 1/2/5/a5/0",
                     wb_valid, wb_warp, wb_reg, wb_data, wb_src);
        else n_pass++;
        step();
        n_checks++;
        if (wb_valid !== 1'b0) $display("FAIL single_drop: got valid %b expected 0", wb_valid);
        else n_pass++;
    endtask

    task automatic test_fairness();
        int prev = -1;
        wb_ack = 1'b1;
        for (int c = 0; c < 24; c++) begin
            drive_random(100);
            for (int i = 0; i < N; i++) src_reg[i] = reg_num_t'($urandom_range(63, 1));
            step();
            if (wb_valid) begin
                if (prev >= 0) begin
                    n_checks++;
                    if (int'(wb_src) !== (prev + 1) % N)
                        $display("FAIL rr_order: got src %0d expected %0d", wb_src, (prev + 1) % N);
                    else n_pass++;
                end
                prev = int'(wb_src);
            end
        end
        idle();
        repeat (20) step();
    endtask

    task automatic test_backpressure();
        reg_num_t got [$];
        wb_ack = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            idle();
            src_valid[1] = 1'b1; src_reg[1] = reg_num_t'(k);
            src_warp[1] = WARP_W'($urandom); src_data[1] = $urandom;
            step();
        end
        idle();
        #1;
        n_checks++;
        if (src_ready[1] !== 1'b0) $display("FAIL bp_full_ready: got %b expected 0", src_ready[1]);
        else n_pass++;
        @(negedge clk);
        wb_ack = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (wb_valid) got.push_back(wb_reg);
            step();
        end
        n_checks++;
        if (got.size() !== 5) $display("FAIL bp_count: got %0d entries expected 5", got.size());
        else n_pass++;
        for (int k = 0; k < got.size() && k < 5; k++) begin
            n_checks++;
            if (got[k] !== reg_num_t'(k + 1)) $display("FAIL bp_order: got reg %0d expected %0d", got[k], k + 1);
            else n_pass++;
        end
    endtask

    task automatic test_reg0();
        int seen = 0;
        wb_ack = 1'b1;
        idle(); src_valid[2] = 1'b1; src_reg[2] = '0; src_data[2] = $urandom;
        step();
        idle(); src_valid[2] = 1'b1; src_reg[2] = 6'd7; src_data[2] = $urandom;
        step();
        idle();
        for (int c = 0; c < 6; c++) begin
            if (wb_valid) begin
                seen++;
                n_checks++;
                if (wb_reg !== 6'd7) $display("FAIL reg0_leak: got reg %0d expected 7", wb_reg);
                else n_pass++;
            end
            step();
        end
        n_checks++;
        if (seen !== 1) $display("FAIL reg0_count: got %0d writebacks expected 1", seen);
        else n_pass++;
    endtask

    task automatic test_stall_reset();
        logic [43:0] held;
        wb_ack = 1'b0;
        for (int c = 0; c < 6; c++) begin drive_random(70); step(); end
        held = {wb_valid, wb_warp, wb_reg, wb_data, wb_src};
        rdy = 1'b0;
        for (int c = 0; c < 3; c++) begin
            drive_random(100); wb_ack = 1'($urandom);
            step();
            n_checks++;
            if ({wb_valid, wb_warp, wb_reg, wb_data, wb_src} !== held)
                $display("FAIL stall_hold: got %h expected %h", {wb_valid, wb_warp, wb_reg, wb_data, wb_src}, held);
            else n_pass++;
        end
        rdy = 1'b1; wb_ack = 1'b1;
        for (int c = 0; c < 6; c++) begin drive_random(60); step(); end
        idle();
        repeat (20) step();
        wb_ack = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idle(); src_valid[0] = 1'b1; src_reg[0] = reg_num_t'(k); src_data[0] = $urandom;
            step();
        end
        idle(); rst = 1'b1;
        step();
        n_checks++;
        if (wb_valid !== 1'b0) $display("FAIL reset_midop: got valid %b expected 0", wb_valid);
        else n_pass++;
        rst = 1'b0; wb_ack = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step();
            n_checks++;
            if (wb_valid !== 1'b0) $display("FAIL reset_stale: got valid %b expected 0", wb_valid);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            drive_random(50);
            rdy    = ($urandom_range(7) != 0);
            wb_ack = ($urandom_range(2) != 0);
            rst    = ($urandom_range(96) == 0);
            step();
        end
        rst = 1'b0; rdy = 1'b1; wb_ack = 1'b1; idle();
        repeat (24) step();
    endtask

`ifdef GELATO_WB_PERF_EN
    task automatic test_perf();
        rst = 1'b1; rdy = 1'b1; wb_ack = 1'b0; idle();
        step();
        rst = 1'b0;
        src_valid[3] = 1'b1; src_reg[3] = 6'd1; step();
        idle(); step();
        src_valid[3] = 1'b1; src_reg[3] = 6'd2; step();
        idle();
        repeat (10) step();
        n_checks++;
        if (perf_stall_cnt !== {16'd10, 16'd0, 16'd0, 16'd0})
            $display("FAIL perf_stall: got %h expected 000a000000000000", perf_stall_cnt);
        else n_pass++;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; rdy = 1'b1; wb_ack = 1'b0; idle();
        m_valid = 1'b0; m_warp = '0; m_reg = '0; m_data = '0; m_src = 0; m_last = N - 1;
        @(negedge clk);
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_reg0();
        test_stall_reset();
        test_random();
`ifdef GELATO_WB_PERF_EN
        test_perf();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
